// File: rtl/vid_in_pkg.sv
// Shared types and helpers for the analog video input deserialiser.
package vid_in_pkg;

  typedef enum logic {
    ST_UNLOCK = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  // Output word width: DDR packs both edges, SDR keeps the rising edge only.
  function automatic int ow_calc(input int lw, input int ddr);
    return (ddr != 0) ? 2 * lw : lw;
  endfunction

endpackage

// File: rtl/vid_in_lock.sv
// Parity-driven link-lock FSM: LOCK_GOOD consecutive good words lock, LOCK_BAD consecutive bad words unlock.
module vid_in_lock
  import vid_in_pkg::*;
#(
  parameter int LOCK_GOOD = 16,
  parameter int LOCK_BAD  = 4,
  parameter int PAR_EN    = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic valid,
  input  logic err,
  output logic lock
);

  localparam int GW = (LOCK_GOOD > 1) ? $clog2(LOCK_GOOD) : 1;
  localparam int BW = (LOCK_BAD > 1) ? $clog2(LOCK_BAD) : 1;
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_GOOD - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(LOCK_BAD - 1);

  lock_state_e   state_q;
  logic [GW-1:0] good_cnt_q;
  logic [BW-1:0] bad_cnt_q;
  logic          lock_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_UNLOCK;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      lock_q     <= 1'b0;
    end else if (PAR_EN == 0) begin
      // Without parity there is nothing to judge; lock simply follows valid data.
      lock_q <= valid;
    end else if (clr) begin
      state_q    <= ST_UNLOCK;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      lock_q     <= 1'b0;
    end else if (valid) begin
      unique case (state_q)
        ST_UNLOCK: begin
          if (err) begin
            good_cnt_q <= '0;
          end else if (good_cnt_q == GOOD_LAST) begin
            state_q   <= ST_LOCKED;
            lock_q    <= 1'b1;
            bad_cnt_q <= '0;
          end else begin
            good_cnt_q <= good_cnt_q + GW'(1);
          end
        end
        ST_LOCKED: begin
          if (!err) begin
            bad_cnt_q <= '0;
          end else if (bad_cnt_q == BAD_LAST) begin
            state_q    <= ST_UNLOCK;
            lock_q     <= 1'b0;
            good_cnt_q <= '0;
          end else begin
            bad_cnt_q <= bad_cnt_q + BW'(1);
          end
        end
      endcase
    end
  end

  assign lock = lock_q;

endmodule

// File: rtl/vid_in_deser.sv
// Video PMOD input PHY: assembles IOB-captured lanes into words, checks parity, stretches reset, tracks lock.
// Define VID_IN_ERR_CNT_EN to build the saturating parity-error counter behind err_cnt.
module vid_in_deser
  import vid_in_pkg::*;
#(
  parameter int LW           = 4,
  parameter int DDR          = 1,
  parameter int PAR_EN       = 1,
  parameter int PAR_ODD      = 0,
  parameter int RST_LEN_LOG2 = 3,
  parameter int LOCK_GOOD    = 16,
  parameter int LOCK_BAD     = 4,
  parameter int ERR_CNT_W    = 16,
  localparam int OW = ow_calc(LW, DDR),
  localparam int IW = LW + PAR_EN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 active,
  input  logic [IW-1:0]        in_rise,
  input  logic [IW-1:0]        in_fall,
  output logic [OW-1:0]        out_data,
  output logic                 out_valid,
  output logic                 out_err,
  output logic                 out_rst,
  output logic                 lock,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_cnt_clr
);

  localparam int CW = RST_LEN_LOG2 + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(1) << RST_LEN_LOG2;

  logic          act_meta_q, active_s_q;
  logic [CW-1:0] rst_cnt_q, rst_cnt_d;
  logic          out_rst_w;
  logic [OW-1:0] word;
  logic          per_r, per_f;
  logic [OW-1:0] out_data_q;
  logic          out_valid_q, out_err_q;

  // NOTE: non-blocking assignments make the two stages shift one per edge instead of collapsing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_meta_q <= 1'b0;
      active_s_q <= 1'b0;
    end else begin
      act_meta_q <= active;
      active_s_q <= act_meta_q;
    end
  end

  // MSB-set counter runs until it wraps to zero, giving exactly 2^RST_LEN_LOG2 cycles of reset.
  always_comb begin
    // NOTE: default first so every path assigns rst_cnt_d and no latch is inferred.
    rst_cnt_d = rst_cnt_q;
    if (!active_s_q) begin
      rst_cnt_d = CNT_LOAD;
    end else if (rst_cnt_q[CW-1]) begin
      rst_cnt_d = rst_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_cnt_q <= CNT_LOAD;
    else        rst_cnt_q <= rst_cnt_d;
  end

  assign out_rst_w = rst_cnt_q[CW-1];

  if (DDR != 0) begin : g_ddr
    assign word  = {in_fall[LW-1:0], in_rise[LW-1:0]};
    assign per_f = (^in_fall) ^ (PAR_ODD != 0);
  end else begin : g_sdr
    assign word  = in_rise[LW-1:0];
    assign per_f = 1'b0;
  end

  assign per_r = (^in_rise) ^ (PAR_ODD != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else if (out_rst_w) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      out_data_q  <= word;
      out_valid_q <= 1'b1;
      out_err_q   <= (PAR_EN != 0) & (per_r | per_f);
    end
  end

  vid_in_lock #(
    .LOCK_GOOD (LOCK_GOOD),
    .LOCK_BAD  (LOCK_BAD),
    .PAR_EN    (PAR_EN)
  ) u_lock (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (out_rst_w),
    .valid (out_valid_q),
    .err   (out_err_q),
    .lock  (lock)
  );

`ifdef VID_IN_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Survives stretched resets and link drops so field errors stay visible; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_cnt_clr) begin
      err_cnt_q <= '0;
    end else if (out_valid_q && out_err_q && !(&err_cnt_q)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_cnt_clr;
  assign unused_err_cnt_clr = err_cnt_clr;
  assign err_cnt = '0;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign out_rst   = out_rst_w;

endmodule

// File: tb/tb_vid_in_deser.sv
// Directed bench for vid_in_deser: reset stretch, word assembly, parity, lock FSM, error counter.
module tb_vid_in_deser;

`ifdef VID_IN_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       active;
  logic [4:0] in_rise;
  logic [4:0] in_fall;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_err;
  logic       out_rst;
  logic       lock;
  logic [1:0] err_cnt;
  logic       err_cnt_clr;

  int n_checks = 0;
  int n_errs   = 0;

  vid_in_deser #(
    .ERR_CNT_W (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .active      (active),
    .in_rise     (in_rise),
    .in_fall     (in_fall),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_err     (out_err),
    .out_rst     (out_rst),
    .lock        (lock),
    .err_cnt     (err_cnt),
    .err_cnt_clr (err_cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane value with even parity in bit 4; bad=1 flips the parity bit.
  function automatic logic [4:0] mk(input logic [3:0] d, input logic bad);
    return {(^d) ^ bad, d};
  endfunction

  // Expected error count, or 0 when the counter is not built.
  function automatic logic [1:0] ec(input int v);
    return CNT_ON ? 2'(v) : 2'd0;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    active      = 1'b1;
    err_cnt_clr = 1'b0;
    in_rise     = mk(4'h1, 1'b0);
    in_fall     = mk(4'h3, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_rst", out_rst, 1);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_err", out_err, 0);
    check("rst_lock", lock, 0);
    check("rst_err_cnt", err_cnt, 0);

    // Startup stretch: out_rst low after edge 10, out_valid high after edge 11.
    rst_n = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      tick();
      check("stretch_rst", out_rst, n < 10);
      check("stretch_valid", out_valid, n >= 11);
    end
    check("word_31", out_data, 8'h31);
    check("word_31_err", out_err, 0);

    in_rise = mk(4'hA, 1'b0);
    in_fall = mk(4'h5, 1'b0);
    tick();
    check("word_5a", out_data, 8'h5A);
    check("word_5a_err", out_err, 0);

    in_rise = mk(4'hF, 1'b0);
    in_fall = mk(4'h0, 1'b0);
    tick();
    check("word_0f", out_data, 8'h0F);

    // Fall-edge parity error.
    in_rise = 5'b1_0001;
    in_fall = 5'b0_0001;
    tick();
    check("perr_fall", out_err, 1);
    check("perr_fall_data", out_data, 8'h11);
    check("perr_fall_cnt0", err_cnt, ec(0));
    in_rise = mk(4'h1, 1'b0);
    in_fall = mk(4'h3, 1'b0);
    tick();
    check("perr_fall_once", out_err, 0);
    check("perr_fall_cnt1", err_cnt, ec(1));

    // Rise-edge parity error, then good words toward lock.
    in_rise = mk(4'h2, 1'b1);
    tick();
    check("perr_rise", out_err, 1);
    in_rise = mk(4'h1, 1'b0);
    tick();
    check("perr_rise_once", out_err, 0);
    check("perr_rise_cnt2", err_cnt, ec(2));
    check("lock_after_bad", lock, 0);

    for (int i = 0; i < 15; i++) begin
      tick();
      check("lock_early", lock, 0);
    end
    tick();
    check("lock_on", lock, 1);

    // Bad, bad, bad, good, bad, bad, bad keeps lock; a fourth consecutive bad drops it.
    for (int i = 0; i < 8; i++) begin
      in_fall = mk(4'h3, (i != 3));
      tick();
      check("lock_hold", lock, 1);
    end
    in_fall = mk(4'h3, 1'b0);
    tick();
    check("lock_drop", lock, 0);
    check("err_cnt_sat_a", err_cnt, ec(3));

    // Clear, then five bad words saturate at 3.
    err_cnt_clr = 1'b1;
    tick();
    check("err_cnt_clr", err_cnt, ec(0));
    err_cnt_clr = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      in_rise = mk(4'h1, 1'b1);
      tick();
      check("err_cnt_ramp", err_cnt, ec((k - 1 > 3) ? 3 : k - 1));
    end
    in_rise = mk(4'h1, 1'b0);
    tick();
    check("err_cnt_sat_b", err_cnt, ec(3));

    // Clear coincides with a pending increment.
    in_rise = mk(4'h1, 1'b1);
    tick();
    check("clr_pending_err", out_err, 1);
    in_rise     = mk(4'h1, 1'b0);
    err_cnt_clr = 1'b1;
    tick();
    check("clr_beats_inc", err_cnt, ec(0));
    err_cnt_clr = 1'b0;
    tick();
    check("clr_hold", err_cnt, ec(0));

    // One error to retain, then relock.
    in_rise = mk(4'h1, 1'b1);
    tick();
    in_rise = mk(4'h1, 1'b0);
    for (int i = 0; i < 17; i++) tick();
    check("relock", lock, 1);
    check("err_cnt_one", err_cnt, ec(1));

    // One-cycle active drop while locked.
    active = 1'b0;
    tick();
    active = 1'b1;
    tick();
    check("drop_sync_delay", out_rst, 0);
    tick();
    check("drop_rst", out_rst, 1);
    tick();
    check("drop_lock", lock, 0);
    check("drop_valid", out_valid, 0);
    check("drop_data", out_data, 0);
    check("drop_rst_hold", out_rst, 1);
    for (int k = 4; k <= 10; k++) begin
      tick();
      check("drop_stretch", out_rst, k < 10);
    end
    tick();
    check("drop_valid_back", out_valid, 1);
    check("drop_err_cnt_kept", err_cnt, ec(1));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/vid_in_deser.md
Name: vid_in_deser

Overview:
- Parametrised successor to the analog video PMOD input PHY.
- Takes lanes already captured by the IOBs on each clock edge (rise/fall from DDR SB_IO) and assembles output words in DDR or SDR mode.
- Checks optional per-edge parity; generates a stretched downstream reset.
- Adds a parity-based link-lock state machine and an error counter.
- Sits between the pad/IOB wrapper and the BT.656 decoder, in the recovered video clock domain.

Parameters:
- LW, 4: payload bits per edge.
- DDR, 1: 1 = word is {fall,rise}, OW = 2*LW; 0 = SDR, word is rise only, OW = LW, fall lanes ignored.
- PAR_EN, 1: 1 = extra top lane (bit LW) carries parity per edge; 0 = no parity bit, errors never flagged.
- PAR_ODD, 0: 0 = even parity (XOR of all LW+1 bits == 0 is good); 1 = odd parity.
- RST_LEN_LOG2, 3: out_rst stretch is 2^RST_LEN_LOG2 cycles.
- LOCK_GOOD, 16: consecutive good words needed to lock.
- LOCK_BAD, 4: consecutive bad words needed to drop lock.
- ERR_CNT_W, 16: error counter width.

Ports:
- clk  in  1  recovered video clock (global buffer).
- rst_n  in  1  async active-low reset.
- active  in  1  async enable; low forces out_rst.
- in_rise  in  LW+PAR_EN  lanes captured on rising edge.
- in_fall  in  LW+PAR_EN  lanes captured on falling edge; valid at the following rising edge.
- out_data  out  OW  assembled word.
- out_valid  out  1  out_data meaningful.
- out_err  out  1  parity error on this word.
- out_rst  out  1  stretched active-high reset for downstream logic.
- lock  out  1  link locked.
- err_cnt  out  ERR_CNT_W  saturating parity-error count.
- err_cnt_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset values under rst_n low: all outputs 0 except out_rst=1; FSM in UNLOCK.
- active synchronisation: 2-FF synchroniser, reset value 0, giving active_s.
- Reset stretch:
  - Counter rst_cnt is RST_LEN_LOG2+1 bits.
  - While rst_n low or active_s==0: load 2^RST_LEN_LOG2 (MSB set).
  - Else, while MSB set: increment.
  - out_rst = MSB (registered).
  - out_rst falls exactly 2^RST_LEN_LOG2 cycles after active_s rises, i.e. 2+2^RST_LEN_LOG2 cycles after active rises.
  - active dropping mid-run reasserts out_rst on the cycle after active_s falls and restarts the full stretch.
- Data path: single register stage, latency 1 cycle from in_* sampled to out_data.
  - out_data <= DDR ? {in_fall[LW-1:0], in_rise[LW-1:0]} : in_rise[LW-1:0].
  - out_valid <= ~out_rst.
  - While out_rst=1: out_data, out_err and out_valid are forced to 0 on the next edge.
- Parity:
  - per_r = ^in_rise ^ PAR_ODD.
  - per_f = DDR ? (^in_fall ^ PAR_ODD) : 0.
  - out_err <= PAR_EN & ~out_rst & (per_r | per_f), aligned with out_data.
  - Fall-edge parity is computed on posedge only; no negedge flops.
- Lock FSM (evaluated only on cycles with out_valid=1):
  - Counters good_cnt and bad_cnt, each clog2-sized.
  - UNLOCK:
    - Good word: good_cnt++. When good_cnt==LOCK_GOOD-1 and the word is good, go to LOCKED and set bad_cnt=0.
    - Bad word: good_cnt=0.
  - LOCKED:
    - Bad word: bad_cnt++. When bad_cnt==LOCK_BAD-1 and the word is bad, go to UNLOCK and set good_cnt=0.
    - Good word: bad_cnt=0.
  - lock = (state==LOCKED), registered; it rises on the edge that consumes the LOCK_GOOD-th good word.
  - out_rst=1 forces UNLOCK and clears both counters.
  - PAR_EN=0: lock <= out_valid.
- Error counter: see Optional Feature.

Optional Feature:
- Macro VID_IN_ERR_CNT_EN.
- Defined:
  - err_cnt increments on each cycle with out_valid & out_err, saturating at all-ones.
  - err_cnt_clr clears err_cnt; clear beats a simultaneous increment, so the result is 0.
  - err_cnt is unaffected by out_rst or active; only rst_n clears it.
- Undefined: err_cnt tied to 0, err_cnt_clr ignored, no counter flops. Ports remain present.

Decomposition:
- Package vid_in_pkg:
  - lock state encodings ST_UNLOCK=1'b0, ST_LOCKED=1'b1.
  - function computing OW from LW/DDR.
- One sub-module, vid_in_lock: the lock FSM plus good/bad counters.
  - Inputs: clk, rst_n, clr (=out_rst), valid, err.
  - Output: lock.
- Stretch, data path and error counter stay in the top.

Test Plan (LW=4, DDR=1, PAR_EN=1, PAR_ODD=0, RST_LEN_LOG2=3, LOCK_GOOD=16, LOCK_BAD=4, macro defined):
- Startup: rst_n release, active=1 at cycle 0 -> out_rst stays 1 through cycle 9, falls at cycle 10; out_valid rises at cycle 11.
- Word assembly: in_rise=5'b1_0001, in_fall=5'b0_0011 (both even parity) -> next cycle out_data=8'h31, out_err=0.
- Parity error: in_fall=5'b0_0001 with a good rise -> out_err=1 for exactly one cycle; err_cnt 0->1.
- Lock: 16 good words -> lock=1 after the 16th. Then 3 bad words, 1 good, 3 bad -> lock stays 1. A 4th consecutive bad word -> lock=0 next cycle.
- Mid-run deassert: active low for 1 cycle while locked -> out_rst=1 within 3 cycles, lock=0, out_valid=0; full 8-cycle stretch restarts; err_cnt is retained.
- Saturation/clear: ERR_CNT_W=2, 5 bad words -> err_cnt=3. err_cnt_clr asserted together with a bad word -> err_cnt=0.
